pkt_lane_sched: RTL

- Packet scheduler for the 24-lane, 36-bit packet generator datapath in pktctrl.
- On a start pulse it snapshots all lanes and the lane-enable mask.
- It then serializes the enabled lanes, lowest index first, into one framed valid/ready stream with a header word.
- Sits between the packet generator and the downstream capture/transport logic; sequences lane readout and shares the single output stream among the 24 lanes.

---
 rtl/pkt_lane_sched.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/pkt_lane_sched.sv
// -----------------------------------------------------------------------------
// pkt_lane_sched
//
// Packet scheduler for the multi-lane packet generator datapath. A start pulse
// accepted while idle snapshots every lane word, the lane-enable mask and the
// enabled-lane count. The block then emits one framed valid/ready packet:
// a header word, followed by the snapshot word of each enabled lane in
// ascending lane order with no bubbles. After the final word is accepted it
// idles for GAP_CYC cycles before accepting the next start.
//
// Header word (MSBs zero-filled above bit 35):
//   {4'hA, seq[15:0], enabled_count[7:0], 8'h00}
//
// Build option:
//   PKT_LANE_SCHED_CHKSUM_EN - when defined, a trailer word is appended that
//   holds the XOR of the header and all data words; eop moves to the trailer.
//
// Ports:
//   clk        block clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle request to capture and send one packet
//   lane_en    per-lane include mask (sampled on accepted start)
//   lane_data  flattened lane words, lane i at [i*DW +: DW]
//   pkt_vld    output word valid
//   pkt_rdy    downstream ready
//   pkt_data   output word
//   pkt_sop    first word of packet (header)
//   pkt_eop    last word of packet
//   busy       high from accepted start until the gap ends
//   start_ovf  one-cycle registered pulse for a start that arrived while busy
//   pkt_cnt    completed packet count, wraps
// -----------------------------------------------------------------------------
module pkt_lane_sched #(
    parameter int unsigned NUM_LANE = 24,
    parameter int unsigned DW       = 36,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_LANE-1:0]    lane_en,
    input  logic [NUM_LANE*DW-1:0] lane_data,
    output logic                   pkt_vld,
    input  logic                   pkt_rdy,
    output logic [DW-1:0]          pkt_data,
    output logic                   pkt_sop,
    output logic                   pkt_eop,
    output logic                   busy,
    output logic                   start_ovf,
    output logic [15:0]            pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
`ifdef PKT_LANE_SCHED_CHKSUM_EN
        S_TRL,
`endif
        S_GAP
    } state_t;

    // Where the FSM goes after the final word of a packet is accepted.
    localparam state_t     AFTER_PKT = (GAP_CYC == 0) ? S_IDLE : S_GAP;
    localparam logic [3:0] GAP_LOAD  = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_LANE*DW-1:0] r_snap;
    logic [NUM_LANE-1:0]    r_mask;       // lanes still to be sent
    logic [7:0]             r_cnt;        // enabled-lane count of this packet
    logic [15:0]            r_pkt_cnt;    // completed packets; doubles as header seq
    logic [3:0]             r_gap;
    logic                   r_start_ovf;
`ifdef PKT_LANE_SCHED_CHKSUM_EN
    logic [DW-1:0]          r_xor;
`endif

    logic [7:0]             w_popcnt;
    logic [DW-1:0]          w_lane_word;
    logic                   w_mask_last;
    logic                   w_xfer;
    logic                   w_last;
    logic [35:0]            w_hdr;

    always_comb begin
        w_popcnt = '0;
        for (int unsigned i = 0; i < NUM_LANE; i++) begin
            w_popcnt = w_popcnt + 8'(lane_en[i]);
        end
    end

    // Priority encoder: scanning downward leaves the lowest remaining lane's
    // word selected, so each handshake steps straight to the next enabled lane.
    always_comb begin
        w_lane_word = '0;
        for (int unsigned i = NUM_LANE; i > 0; i--) begin
            if (r_mask[i-1]) begin
                w_lane_word = r_snap[(i-1)*DW +: DW];
            end
        end
    end

    // Exactly one lane left: the current data word is the last one.
    assign w_mask_last = ((r_mask & (r_mask - NUM_LANE'(1))) == '0);
    assign w_hdr       = {4'hA, r_pkt_cnt, r_cnt, 8'h00};
    assign w_xfer      = pkt_vld & pkt_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs depend only on registered state; pkt_rdy only steers next state.
    always_comb begin
        w_state_nxt = r_state;
        pkt_vld     = 1'b0;
        pkt_sop     = 1'b0;
        pkt_data    = '0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                pkt_vld  = 1'b1;
                pkt_sop  = 1'b1;
                pkt_data = DW'(w_hdr);
`ifndef PKT_LANE_SCHED_CHKSUM_EN
                w_last   = (r_cnt == 8'd0);
`endif
                if (pkt_rdy) begin
                    if (r_cnt != 8'd0) begin
                        w_state_nxt = S_DATA;
                    end else begin
`ifdef PKT_LANE_SCHED_CHKSUM_EN
                        w_state_nxt = S_TRL;
`else
                        w_state_nxt = AFTER_PKT;
`endif
                    end
                end
            end
            S_DATA: begin
                pkt_vld  = 1'b1;
                pkt_data = w_lane_word;
`ifndef PKT_LANE_SCHED_CHKSUM_EN
                w_last   = w_mask_last;
`endif
                if (pkt_rdy && w_mask_last) begin
`ifdef PKT_LANE_SCHED_CHKSUM_EN
                    w_state_nxt = S_TRL;
`else
                    w_state_nxt = AFTER_PKT;
`endif
                end
            end
`ifdef PKT_LANE_SCHED_CHKSUM_EN
            S_TRL: begin
                pkt_vld  = 1'b1;
                pkt_data = r_xor;
                w_last   = 1'b1;
                if (pkt_rdy) begin
                    w_state_nxt = AFTER_PKT;
                end
            end
`endif
            S_GAP: begin
                if (r_gap == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign pkt_eop   = w_last;
    assign busy      = (r_state != S_IDLE);
    assign start_ovf = r_start_ovf;
    assign pkt_cnt   = r_pkt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap      <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_pkt_cnt   <= '0;
            r_gap       <= '0;
            r_start_ovf <= 1'b0;
`ifdef PKT_LANE_SCHED_CHKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_start_ovf <= start && (r_state != S_IDLE);

            if ((r_state == S_IDLE) && start) begin
                r_snap <= lane_data;
                r_mask <= lane_en;
                r_cnt  <= w_popcnt;
`ifdef PKT_LANE_SCHED_CHKSUM_EN
                r_xor  <= '0;
`endif
            end

            if ((r_state == S_DATA) && w_xfer) begin
                r_mask <= r_mask & (r_mask - NUM_LANE'(1));
            end

`ifdef PKT_LANE_SCHED_CHKSUM_EN
            if (w_xfer) begin
                r_xor <= r_xor ^ pkt_data;
            end
`endif

            // Gap counter is loaded with GAP_CYC-1 so GAP lasts GAP_CYC cycles.
            if (w_xfer && w_last) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
                r_gap     <= GAP_LOAD;
            end else if ((r_state == S_GAP) && (r_gap != 4'd0)) begin
                r_gap <= r_gap - 4'd1;
            end
        end
    end

endmodule
